// File: rtl/dm_cache_controller_if.sv
// Line-wide request/response channel between the cache (master) and the memory model (slave).
// The master holds valid/write/addr/wr_data; the slave answers with ready and rd_data.
interface memory_interface #(
    parameter int ADDR_SIZE = 32,
    parameter int LINE_SIZE = 256
);
    logic                 valid;
    logic                 write;
    logic [ADDR_SIZE-1:0] addr;
    logic [LINE_SIZE-1:0] wr_data;
    logic [LINE_SIZE-1:0] rd_data;
    logic                 ready;

    modport master (output valid, write, addr, wr_data, input rd_data, ready);
    modport slave  (input valid, write, addr, wr_data, output rd_data, ready);
endinterface

// File: rtl/dm_cache_controller.sv
// Direct-mapped, write-back, write-allocate cache with zero-cycle hits.
// Misses write back a dirty victim, then fill the line over memory_interface.
module dm_cache_controller #(
    parameter int ADDR_SIZE = 32,
    parameter int LINE_SIZE = 256,
    parameter int WORD_SIZE = 32,
    parameter int NUM_SETS  = 64
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   cpu_valid_i,
    input  logic [ADDR_SIZE-1:0]   cpu_addr_i,
    input  logic                   cpu_write_i,
    input  logic [WORD_SIZE-1:0]   cpu_wr_data_i,
    input  logic [WORD_SIZE/8-1:0] cpu_wr_be_i,
    output logic                   cpu_ready_o,
    output logic [WORD_SIZE-1:0]   cpu_rd_data_o,
    memory_interface.master        memory_bus
);
    localparam int OFFSET_BITS = $clog2(LINE_SIZE/8);
    localparam int INDEX_BITS  = $clog2(NUM_SETS);
    localparam int TAG_BITS    = ADDR_SIZE - INDEX_BITS - OFFSET_BITS;
    localparam int BYTE_BITS   = $clog2(WORD_SIZE/8);
    localparam int WSEL_BITS   = OFFSET_BITS - BYTE_BITS;
    localparam int WBIT_BITS   = $clog2(WORD_SIZE);
    localparam int LBIT_BITS   = $clog2(LINE_SIZE);
    localparam int WORD_BYTES  = WORD_SIZE/8;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_WAIT,
        FILL_REQ,
        FILL_WAIT
    } state_e;

    state_e state_q, state_d;

    logic [NUM_SETS-1:0]  valid_q;
    logic [NUM_SETS-1:0]  dirty_q;
    logic [TAG_BITS-1:0]  tag_q  [NUM_SETS];
    logic [LINE_SIZE-1:0] line_q [NUM_SETS];

    logic [ADDR_SIZE-1:0] mem_addr_q;
    logic [LINE_SIZE-1:0] mem_wr_data_q;

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [WSEL_BITS-1:0]  req_wsel;
    logic [BYTE_BITS-1:0]  unused_addr_bits;
    logic [LBIT_BITS-1:0]  word_lsb;
    logic [ADDR_SIZE-1:0]  fill_addr;
    logic [ADDR_SIZE-1:0]  victim_addr;
    logic [LINE_SIZE-1:0]  cur_line;
    logic [LINE_SIZE-1:0]  store_line;
    logic                  hit;
    logic                  store_hit;

    assign req_tag          = cpu_addr_i[ADDR_SIZE-1 -: TAG_BITS];
    assign req_idx          = cpu_addr_i[OFFSET_BITS +: INDEX_BITS];
    assign req_wsel         = cpu_addr_i[OFFSET_BITS-1 : BYTE_BITS];
    assign unused_addr_bits = cpu_addr_i[BYTE_BITS-1:0];
    assign word_lsb         = {req_wsel, {WBIT_BITS{1'b0}}};

    assign fill_addr   = {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
    assign victim_addr = {tag_q[req_idx], req_idx, {OFFSET_BITS{1'b0}}};
    assign cur_line    = line_q[req_idx];

    // Tags of never-filled sets are garbage; valid_q masks them out.
    assign hit       = cpu_valid_i && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign store_hit = cpu_ready_o && cpu_write_i;

    assign cpu_ready_o   = (state_q == IDLE) && hit;
    assign cpu_rd_data_o = cur_line[word_lsb +: WORD_SIZE];

    always_comb begin
        store_line = cur_line;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (cpu_wr_be_i[b]) begin
                store_line[word_lsb + LBIT_BITS'(8*b) +: 8] = cpu_wr_data_i[8*b +: 8];
            end
        end
    end

    assign memory_bus.valid   = (state_q == WB_REQ) || (state_q == FILL_REQ);
    assign memory_bus.write   = (state_q == WB_REQ) || (state_q == WB_WAIT);
    assign memory_bus.addr    = mem_addr_q;
    assign memory_bus.wr_data = mem_wr_data_q;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // In REQ states ready means acceptance; in WAIT states it means completion.
    always_comb begin
        // NOTE: default first so no branch leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_valid_i && !hit) begin
                    state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WB_REQ : FILL_REQ;
                end
            end
            WB_REQ:    if (memory_bus.ready) state_d = WB_WAIT;
            WB_WAIT:   if (memory_bus.ready) state_d = FILL_REQ;
            FILL_REQ:  if (memory_bus.ready) state_d = FILL_WAIT;
            FILL_WAIT: if (memory_bus.ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_q       <= '0;
            dirty_q       <= '0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (store_hit) begin
                        dirty_q[req_idx] <= 1'b1;
                    end
                    if (state_d == WB_REQ) begin
                        mem_addr_q    <= victim_addr;
                        mem_wr_data_q <= cur_line;
                    end else if (state_d == FILL_REQ) begin
                        mem_addr_q    <= fill_addr;
                    end
                end
                WB_WAIT: begin
                    if (memory_bus.ready) begin
                        dirty_q[req_idx] <= 1'b0;
                        mem_addr_q       <= fill_addr;
                    end
                end
                FILL_WAIT: begin
                    if (memory_bus.ready) begin
                        valid_q[req_idx] <= 1'b1;
                        dirty_q[req_idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: tag/line arrays carry no reset; only valid_q/dirty_q need a known state.
    always_ff @(posedge clk_i) begin
        if (state_q == FILL_WAIT && memory_bus.ready) begin
            line_q[req_idx] <= memory_bus.rd_data;
            tag_q[req_idx]  <= req_tag;
        end else if (store_hit) begin
            line_q[req_idx] <= store_line;
        end
    end

endmodule

// File: tb/tb_dm_cache_controller.sv
// Directed bench for dm_cache_controller with a line-wide memory slave model.
// Reads occupy the slave 2*DELAY_CYCLES+1 cycles, writebacks DELAY_CYCLES.
module tb_dm_cache_controller;
    localparam int DELAY_CYCLES = 5;
    localparam int RD_BUSY      = 2*DELAY_CYCLES + 1;
    localparam int CLEAN_LAT    = 2*DELAY_CYCLES + 4;
    localparam int DIRTY_LAT    = CLEAN_LAT + DELAY_CYCLES + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        slave_rst_n;
    logic        cpu_valid;
    logic [31:0] cpu_addr;
    logic        cpu_write;
    logic [31:0] cpu_wr_data;
    logic [3:0]  cpu_wr_be;
    logic        cpu_ready;
    logic [31:0] cpu_rd_data;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    memory_interface #(.ADDR_SIZE(32), .LINE_SIZE(256)) mem_bus ();

    dm_cache_controller #(
        .ADDR_SIZE(32), .LINE_SIZE(256), .WORD_SIZE(32), .NUM_SETS(64)
    ) dut (
        .clk_i        (clk),
        .reset_ni     (rst_n),
        .cpu_valid_i  (cpu_valid),
        .cpu_addr_i   (cpu_addr),
        .cpu_write_i  (cpu_write),
        .cpu_wr_data_i(cpu_wr_data),
        .cpu_wr_be_i  (cpu_wr_be),
        .cpu_ready_o  (cpu_ready),
        .cpu_rd_data_o(cpu_rd_data),
        .memory_bus   (mem_bus)
    );

    function automatic logic [31:0] pattern_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [255:0] pattern_line(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = pattern_word(a + 32'(4*w));
        return l;
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory slave: covers byte addresses 0x0000-0x3FFF, preloaded with pattern_word.
    logic [255:0] slave_mem [512];
    int           s_cnt;
    logic         s_cmpl;
    int           rd_count, wr_count;
    logic [31:0]  last_rd_addr, last_wr_addr;
    logic [255:0] last_wr_data;

    always @(posedge clk or negedge slave_rst_n) begin
        if (!slave_rst_n) begin
            mem_bus.ready   <= 1'b1;
            mem_bus.rd_data <= '0;
            s_cnt           <= 0;
            s_cmpl          <= 1'b0;
            rd_count        <= 0;
            wr_count        <= 0;
            last_rd_addr    <= '0;
            last_wr_addr    <= '0;
            last_wr_data    <= '0;
            for (int i = 0; i < 512; i++) slave_mem[i] <= pattern_line(32'(i) << 5);
        end else begin
            s_cmpl <= (s_cnt == 1);
            if (s_cnt != 0) begin
                s_cnt <= s_cnt - 1;
                if (s_cnt == 1) mem_bus.ready <= 1'b1;
            end else if (mem_bus.valid && mem_bus.ready) begin
                mem_bus.ready <= 1'b0;
                if (mem_bus.write) begin
                    slave_mem[mem_bus.addr[13:5]] <= mem_bus.wr_data;
                    s_cnt        <= DELAY_CYCLES;
                    wr_count     <= wr_count + 1;
                    last_wr_addr <= mem_bus.addr;
                    last_wr_data <= mem_bus.wr_data;
                end else begin
                    mem_bus.rd_data <= slave_mem[mem_bus.addr[13:5]];
                    s_cnt        <= RD_BUSY;
                    rd_count     <= rd_count + 1;
                    last_rd_addr <= mem_bus.addr;
                end
            end
        end
    end

    // A request may not appear while one is outstanding or in its completion cycle.
    logic mon_en = 1'b0;
    int   viol   = 0;
    always @(negedge clk) begin
        if (mon_en && mem_bus.valid && (s_cnt != 0 || s_cmpl)) viol <= viol + 1;
    end

    task automatic cpu_op(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output int lat);
        @(negedge clk);
        cpu_valid   = 1'b1;
        cpu_write   = wr;
        cpu_addr    = addr;
        cpu_wr_data = wdata;
        cpu_wr_be   = be;
        lat = 0;
        #1;
        while (!cpu_ready && lat < 200) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check("ready_in_budget", 256'(cpu_ready), 256'(1));
        rdata = cpu_rd_data;
        @(posedge clk);
        #1;
        cpu_valid = 1'b0;
        cpu_wr_be = 4'b0;
    endtask

    logic [31:0] gold [1024];

    initial begin
        int           lat, rc, wc;
        logic [31:0]  rd, a;
        logic [255:0] exp_line;
        logic [3:0]   be;
        logic [31:0]  wd;
        int           wi;

        rst_n = 1'b0; slave_rst_n = 1'b0;
        cpu_valid = 1'b1; cpu_addr = 32'h1000; cpu_write = 1'b0;
        cpu_wr_data = '0; cpu_wr_be = '0;
        #12;
        check("rst_cpu_ready", 256'(cpu_ready), 256'(0));
        check("rst_bus_valid", 256'(mem_bus.valid), 256'(0));
        check("rst_bus_write", 256'(mem_bus.write), 256'(0));
        check("rst_bus_addr", 256'(mem_bus.addr), 256'(0));
        check("rst_bus_wdata", mem_bus.wr_data, 256'(0));
        slave_rst_n = 1'b1;
        cpu_valid   = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // 1: cold load fills, repeat load hits with no bus traffic
        rc = rd_count; wc = wr_count;
        cpu_op(1'b0, 32'h1000, '0, 4'h0, rd, lat);
        check("t1_data", 256'(rd), 256'(32'hEFFF_1000));
        check("t1_lat", 256'(lat), 256'(CLEAN_LAT));
        check("t1_fills", 256'(rd_count - rc), 256'(1));
        check("t1_fill_addr", 256'(last_rd_addr), 256'(32'h1000));
        check("t1_no_wb", 256'(wr_count - wc), 256'(0));
        rc = rd_count;
        cpu_op(1'b0, 32'h1000, '0, 4'h0, rd, lat);
        check("t1_hit_data", 256'(rd), 256'(32'hEFFF_1000));
        check("t1_hit_lat", 256'(lat), 256'(0));
        check("t1_hit_nobus", 256'(rd_count - rc), 256'(0));

        // 2: partial store hit then load back
        cpu_op(1'b1, 32'h1004, 32'hDEAD_BEEF, 4'b0011, rd, lat);
        check("t2_st_lat", 256'(lat), 256'(0));
        cpu_op(1'b0, 32'h1004, '0, 4'h0, rd, lat);
        check("t2_ld_data", 256'(rd), 256'(32'hEFFB_BEEF));
        check("t2_no_wb", 256'(wr_count - wc), 256'(0));

        // 3: conflicting tag on dirty set -> writeback then fill
        exp_line = pattern_line(32'h1000);
        exp_line[63:32] = 32'hEFFB_BEEF;
        rc = rd_count; wc = wr_count;
        cpu_op(1'b0, 32'h1800, '0, 4'h0, rd, lat);
        check("t3_data", 256'(rd), 256'(32'hE7FF_1800));
        check("t3_lat", 256'(lat), 256'(DIRTY_LAT));
        check("t3_wbs", 256'(wr_count - wc), 256'(1));
        check("t3_wb_addr", 256'(last_wr_addr), 256'(32'h1000));
        check("t3_wb_line", last_wr_data, exp_line);
        check("t3_fill_addr", 256'(last_rd_addr), 256'(32'h1800));

        // 4: conflict on clean set -> fill only; data comes back from the writeback
        rc = rd_count; wc = wr_count;
        cpu_op(1'b0, 32'h1004, '0, 4'h0, rd, lat);
        check("t4_data", 256'(rd), 256'(32'hEFFB_BEEF));
        check("t4_lat", 256'(lat), 256'(CLEAN_LAT));
        check("t4_no_wb", 256'(wr_count - wc), 256'(0));
        check("t4_fills", 256'(rd_count - rc), 256'(1));

        // 5: reset during FILL_WAIT, then the held load misses again
        mon_en = 1'b0;
        rc = rd_count;
        @(negedge clk);
        cpu_valid = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h2040;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_bus_valid", 256'(mem_bus.valid), 256'(0));
        check("t5_bus_write", 256'(mem_bus.write), 256'(0));
        check("t5_bus_addr", 256'(mem_bus.addr), 256'(0));
        check("t5_bus_wdata", mem_bus.wr_data, 256'(0));
        check("t5_cpu_ready", 256'(cpu_ready), 256'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t5_remiss", 256'(cpu_ready), 256'(0));
        lat = 0;
        while (!cpu_ready && lat < 200) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check("t5_ready_in_budget", 256'(cpu_ready), 256'(1));
        check("t5_data", 256'(cpu_rd_data), 256'(32'hDFBF_2040));
        check("t5_fills", 256'(rd_count - rc), 256'(2));
        check("t5_fill_addr", 256'(last_rd_addr), 256'(32'h2040));
        @(posedge clk);
        #1;
        cpu_valid = 1'b0;
        lat = 0;
        while ((s_cnt != 0 || s_cmpl) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        mon_en = 1'b1;

        // 6: random load/store stream over 0x3000-0x3FFF vs word model
        for (int i = 0; i < 1024; i++) gold[i] = pattern_word(32'h3000 + 32'(4*i));
        for (int n = 0; n < 80; n++) begin
            wi = int'($urandom_range(0, 1023));
            a  = 32'h3000 + 32'(4*wi);
            if ($urandom_range(0, 1) == 1) begin
                be = 4'($urandom_range(1, 15));
                wd = $urandom;
                cpu_op(1'b1, a, wd, be, rd, lat);
                for (int b = 0; b < 4; b++) if (be[b]) gold[wi][8*b +: 8] = wd[8*b +: 8];
            end else begin
                cpu_op(1'b0, a, '0, 4'h0, rd, lat);
                check("t6_load", 256'(rd), 256'(gold[wi]));
            end
        end
        for (int i = 0; i < 1024; i += 37) begin
            cpu_op(1'b0, 32'h3000 + 32'(4*i), '0, 4'h0, rd, lat);
            check("t6_sweep", 256'(rd), 256'(gold[i]));
        end

        @(negedge clk);
        check("protocol_violations", 256'(viol), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
